cpu_req_gen: RTL and testbench



---
 rtl/cpu_req_gen.sv | 94 +++++++++
 tb/tb_cpu_req_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_gen.sv
// CPU-side request generator: each synchronized rising edge of trig issues the next fixed-pattern request.
// Latency: cs rises on the 2nd clk edge that samples trig high; no backpressure, rises during a request are dropped.
module cpu_req_gen #(
  parameter int unsigned CS_HOLD = 1,
  parameter bit          LOOP    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  output logic [15:0] Address,
  output logic        wr_rd,
  output logic        cs,
  output logic [7:0]  DOut
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(CS_HOLD - 1);

  state_t      state;
  logic        s1;
  logic        s2;
  logic        rise;
  logic [2:0]  idx;
  logic [3:0]  hold_cnt;
  logic [15:0] tbl_addr;
  logic        tbl_wr;
  logic [7:0]  tbl_dat;

  assign rise = s1 & ~s2;

  always_comb begin
    tbl_addr = 16'h0000;
    tbl_wr   = 1'b0;
    tbl_dat  = 8'h00;
    case (idx)
      3'd0: begin tbl_addr = 16'h0000; tbl_wr = 1'b1; tbl_dat = 8'h11; end
      3'd1: begin tbl_addr = 16'h0000; tbl_wr = 1'b0; end
      3'd2: begin tbl_addr = 16'h0102; tbl_wr = 1'b1; tbl_dat = 8'h22; end
      3'd3: begin tbl_addr = 16'h0102; tbl_wr = 1'b0; end
      3'd4: begin tbl_addr = 16'h1100; tbl_wr = 1'b0; end
      3'd5: begin tbl_addr = 16'h1100; tbl_wr = 1'b1; tbl_dat = 8'h33; end
      3'd6: begin tbl_addr = 16'h0000; tbl_wr = 1'b0; end
      3'd7: begin tbl_addr = 16'h1100; tbl_wr = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= IDLE;
      idx      <= 3'd0;
      hold_cnt <= 4'd0;
      Address  <= 16'h0000;
      wr_rd    <= 1'b0;
      cs       <= 1'b0;
      DOut     <= 8'h00;
    end else begin
      s1 <= trig;
      s2 <= s1;
      case (state)
        IDLE: begin
          if (rise) begin
            Address  <= tbl_addr;
            wr_rd    <= tbl_wr;
            DOut     <= tbl_wr ? tbl_dat : 8'h00;
            cs       <= 1'b1;
            hold_cnt <= HOLD_INIT;
            state    <= REQ;
          end
        end
        REQ: begin
          // A rise seen here, including on the exit edge, is intentionally lost.
          if (hold_cnt == 4'd0) begin
            cs <= 1'b0;
            if (idx == 3'd7 && !LOOP) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        DONE: cs <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_req_gen.sv
// Bench for cpu_req_gen: three parameterizations share clk/rst/trig and are checked against an edge-numbered model.
module tb_cpu_req_gen;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic trig = 1'b0;

  logic [2:0][15:0] addr_o;
  logic [2:0][7:0]  dat_o;
  logic [2:0]       wr_o;
  logic [2:0]       cs_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_req_gen #(.CS_HOLD(1), .LOOP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .trig(trig),
    .Address(addr_o[0]), .wr_rd(wr_o[0]), .cs(cs_o[0]), .DOut(dat_o[0]));
  cpu_req_gen #(.CS_HOLD(4), .LOOP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .trig(trig),
    .Address(addr_o[1]), .wr_rd(wr_o[1]), .cs(cs_o[1]), .DOut(dat_o[1]));
  cpu_req_gen #(.CS_HOLD(1), .LOOP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .trig(trig),
    .Address(addr_o[2]), .wr_rd(wr_o[2]), .cs(cs_o[2]), .DOut(dat_o[2]));

  localparam int          HOLD     [3] = '{1, 4, 1};
  localparam bit          LP       [3] = '{1'b1, 1'b1, 1'b0};
  localparam logic [15:0] REF_ADDR [8] = '{16'h0000, 16'h0000, 16'h0102, 16'h0102,
                                           16'h1100, 16'h1100, 16'h0000, 16'h1100};
  localparam bit          REF_WR   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0]  REF_DAT  [8] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00};

  // Model: a request starting at edge s keeps cs high after edges s..s+HOLD-1;
  // the next request can only start at edge s+HOLD+1 or later.
  int          m_edge;
  logic        m_p1, m_p2;
  int          m_served [3];
  int          m_next   [3];
  int          m_csend  [3];
  logic        m_cs     [3];
  logic [24:0] m_fields [3];

  function automatic logic [31:0] act(input int i);
    return {6'd0, cs_o[i], wr_o[i], addr_o[i], dat_o[i]};
  endfunction

  function automatic logic [31:0] expv(input int i);
    return {6'd0, m_cs[i], m_fields[i]};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_p1   = 1'b0;
    m_p2   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_served[i] = 0;
      m_next[i]   = 0;
      m_csend[i]  = 0;
      m_cs[i]     = 1'b0;
      m_fields[i] = '0;
    end
  endtask

  task automatic model_step(input logic t);
    logic rise;
    int   e;
    rise = m_p1 & ~m_p2;
    for (int i = 0; i < 3; i++) begin
      if (rise && m_edge >= m_next[i] && (LP[i] || m_served[i] < 8)) begin
        e           = m_served[i] % 8;
        m_fields[i] = {REF_WR[e], REF_ADDR[e], REF_WR[e] ? REF_DAT[e] : 8'h00};
        m_csend[i]  = m_edge + HOLD[i];
        m_next[i]   = m_edge + HOLD[i] + 1;
        m_served[i]++;
      end
      m_cs[i] = (m_edge < m_csend[i]);
    end
    m_p2 = m_p1;
    m_p1 = t;
    m_edge++;
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic cycle(input logic t, input logic r, input bit chk, input string nm);
    @(negedge clk);
    trig = t;
    rst  = r;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_step(t);
    #1;
    if (chk)
      for (int i = 0; i < 3; i++) cmp($sformatf("%s[%0d]", nm, i), act(i), expv(i));
  endtask

  typedef struct {
    logic        trig;
    logic        cs;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  dat;
  } vec_t;

  vec_t vecs [13];

  int          pulses [3];
  int          run_len;
  logic [2:0]  prev_cs;
  logic [31:0] ninth;
  logic        t;
  logic        r;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 8'h11};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'h11};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'h11};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h11};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'h11};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0102, 8'h22};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0102, 8'h22};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0102, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0102, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0102, 8'h00};

    #1 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) cmp($sformatf("reset_state[%0d]", i), act(i), 32'd0);

    // Reset held while trig toggles: nothing may come out.
    for (int k = 0; k < 8; k++) begin
      cycle(logic'(k % 2), 1'b0, 1'b0, "rst_toggle");
      for (int i = 0; i < 3; i++) cmp($sformatf("rst_toggle[%0d]", i), act(i), 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b1, "rst_settle");

    // Table-driven: single trigger, held trig, and the first entries in order.
    for (int k = 0; k < 13; k++) begin
      cycle(vecs[k].trig, 1'b1, 1'b0, "vec");
      cmp($sformatf("vec%0d", k), act(0),
          {6'd0, vecs[k].cs, vecs[k].wr, vecs[k].addr, vecs[k].dat});
    end

    // Toggle every clock: full table and wrap on dut_a, 4-cycle holds on dut_b, stop after 8 on dut_c.
    cycle(1'b0, 1'b0, 1'b1, "pre_toggle");
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    prev_cs = 3'b000;
    run_len = 0;
    ninth   = '0;
    for (int k = 0; k < 40; k++) begin
      cycle(logic'((k % 2) == 0), 1'b1, 1'b1, "toggle");
      for (int i = 0; i < 3; i++) begin
        if (cs_o[i] && !prev_cs[i]) begin
          pulses[i]++;
          if (i == 0 && pulses[0] == 9) ninth = act(0);
        end
      end
      if (cs_o[1]) run_len++;
      if (!cs_o[1] && prev_cs[1]) begin
        cmp("hold4_run_len", run_len, 4);
        run_len = 0;
      end
      prev_cs = cs_o;
    end
    cmp("toggle_pulses_a", pulses[0], 20);
    cmp("toggle_pulses_b", pulses[1], 7);
    cmp("loop0_pulses_c", pulses[2], 8);
    cmp("wrap_ninth", ninth, {6'd0, 1'b1, 1'b1, 16'h0000, 8'h11});
    cmp("loop0_last_c", act(2), {6'd0, 1'b0, 1'b0, 16'h1100, 8'h00});

    // Mid-request reset drops cs between clock edges; restart begins at entry 0.
    cycle(1'b0, 1'b0, 1'b1, "mid_pre");
    cycle(1'b0, 1'b1, 1'b1, "mid_idle");
    cycle(1'b1, 1'b1, 1'b1, "mid_samp");
    cycle(1'b1, 1'b1, 1'b1, "mid_req");
    cmp("mid_cs_high", {31'd0, cs_o[0]}, 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) cmp($sformatf("mid_async[%0d]", i), act(i), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, "mid_hold");
    cycle(1'b0, 1'b1, 1'b1, "mid_rel");
    cycle(1'b1, 1'b1, 1'b1, "mid_trig");
    cycle(1'b0, 1'b1, 1'b1, "mid_first");
    cmp("mid_restart_entry0", act(0), {6'd0, 1'b1, 1'b1, 16'h0000, 8'h11});

    // Random trig with occasional synchronous-looking and mid-cycle resets.
    t = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) t = ~t;
      r = ($urandom_range(0, 249) != 0);
      cycle(t, r, 1'b1, "rand");
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) cmp($sformatf("rand_async[%0d]", i), act(i), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
